spi_input_controller: RTL and testbench
=======================================

Name: spi_input_controller

Overview:
SPI slave receiver (mode 0, MSB first) for the digit-recognizer host link. It deserializes MOSI into bytes and decodes command bytes. It streams image pixels into the image buffer with a write address, and produces the byte-strobe and SCK-edge pulses that SPI_output_controller consumes. It sits between the SPI pins and both the image buffer and SPI_output_controller.

Parameters:
NUM_PIXELS, 784, number of pixel bytes per image frame
ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= NUM_PIXELS
CMD_COST, 8'h01, command byte requesting the cost value
CMD_IMAGE, 8'h02, command byte starting an image load

Ports:
clk  input  1  system clock; the only clock in the block
rst  input  1  asynchronous, active-high reset
SCK  input  1  SPI clock from host, asynchronous to clk
SS  input  1  SPI slave select, active low, asynchronous
MOSI  input  1  SPI data from host, asynchronous
SPI_in  output  8  last complete received byte, held until the next byte completes
shift_SPI  output  1  1-cycle pulse: SPI_in was just updated
sig_edge  output  1  1-cycle pulse on each synchronized SCK falling edge while SS is low
cost_req  output  1  1-cycle pulse: CMD_COST received
pixel_data  output  8  pixel byte to the image buffer
pixel_addr  output  ADDR_W  pixel write address
pixel_wr  output  1  1-cycle pixel write strobe
image_loaded  output  1  1-cycle pulse: all NUM_PIXELS pixels written

Behaviour:
- Reset values:
  - All outputs are 0.
  - SPI_in = 8'h00.
  - FSM = IDLE; bit counter = 0; pixel address = 0.
  - Synchronizer flops reset to SCK=0, SS=1, MOSI=0.
- Synchronization and edge detection:
  - SCK, SS and MOSI each pass through 2 flops.
  - A third SCK flop provides edge detection.
  - A rising edge is detected 3 clk cycles after the pin transition; MOSI is sampled from the synchronized flop in that same cycle.
  - sig_edge = synchronized SCK falling edge AND synchronized SS low.
- Byte assembly:
  - Left shift on each detected rising edge while SS is low; the first bit received is the MSB.
  - A 3-bit counter tracks bits. On the 8th bit, the counter wraps to 0 and the assembled byte is loaded into SPI_in.
  - shift_SPI is registered and pulses in the clk cycle after the 8th rising edge is detected. SPI_in is valid in the same cycle.
- SS deassertion (synchronized rising):
  - Clears the bit counter and discards any partial byte.
  - SPI_in keeps its last complete value.
  - FSM returns to IDLE from any state.
  - Takes priority over a byte completing in the same cycle; that byte is dropped.
- FSM states: IDLE, CMD, PIXELS, DONE.
  - IDLE: synchronized SS falling edge -> CMD.
  - CMD, byte == CMD_COST: cost_req pulses with shift_SPI; stay in CMD.
  - CMD, byte == CMD_IMAGE: pixel address cleared to 0 -> PIXELS.
  - CMD, any other byte: ignored; stay in CMD.
  - PIXELS: each byte drives pixel_data = byte, pixel_addr = current address and pixel_wr = 1, all aligned with shift_SPI. The address then increments.
  - PIXELS, the write at address NUM_PIXELS-1: next state DONE; the address does not wrap past NUM_PIXELS-1.
  - DONE: image_loaded pulses for 1 cycle -> CMD. A byte cannot complete during DONE, since a byte needs at least 8 SCK edges.
- Partial image (SS rises in PIXELS): image_loaded never asserts. The pixels already written remain in the buffer.
- Reset mid-frame: all state clears immediately; no pulse outputs are generated.
- The host must hold SCK low for at least 4 clk cycles per phase; the block does not check this.

Optional Feature:
PIXEL_THRESH_EN
- Defined: pixel_data = 8'hFF if the received byte >= 8'h80, else 8'h00 (binarized image).
- Not defined: pixel_data = received byte unchanged.
- SPI_in is raw in both cases.

Test Plan:
- Reset: assert rst during SCK activity -> all outputs 0, SPI_in = 8'h00; no pulses after release until a new SS frame.
- Byte receive: SS low, shift 8'hA5 MSB first -> exactly one shift_SPI with SPI_in = 8'hA5; 8 sig_edge pulses.
- Cost command: SS low, send 8'h01, then 8'h01 again -> two cost_req pulses, each coincident with shift_SPI; no pixel_wr.
- Image load: send 8'h02, then 784 bytes with value = index mod 256 -> 784 pixel_wr pulses with pixel_addr 0..783 and matching pixel_data; one image_loaded pulse after address 783; a following 8'h01 produces cost_req.
- Abort: send 8'h02 and 10 pixels, then raise SS after 5 bits of byte 11 -> 10 pixel_wr, no image_loaded, SPI_in = pixel 10. A new frame sending 8'h02 restarts at address 0.
- Unknown command and threshold: send 8'h7E -> no cost_req or pixel_wr. With PIXEL_THRESH_EN, pixels 8'h80 and 8'h7F -> pixel_data 8'hFF and 8'h00.

Source files
------------

// File: rtl/spi_input_controller.sv
// spi_input_controller: mode-0 SPI slave receiver for the digit-recognizer
// host link. Deserializes MOSI MSB-first, decodes command bytes and streams
// image pixels into the image buffer.
// Optional build macro: PIXEL_THRESH_EN binarizes pixel bytes (>=0x80 -> 0xFF,
// else 0x00). SPI_in always carries the raw byte.
module spi_input_controller #(
  parameter int          NUM_PIXELS = 784,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  CMD_COST   = 8'h01,
  parameter logic [7:0]  CMD_IMAGE  = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic [7:0]        SPI_in,
  output logic              shift_SPI,
  output logic              sig_edge,
  output logic              cost_req,
  output logic [7:0]        pixel_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_wr,
  output logic              image_loaded
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, CMD, PIXELS, DONE} state_t;

  state_t              state;
  logic                sck_s1, sck_s2, sck_s3;
  logic                ss_s1, ss_s2, ss_s3;
  logic                mosi_s1, mosi_s2;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic [ADDR_W-1:0]   addr_q;

  logic                sck_rise, sck_fall, ss_rise, ss_fall;
  logic                bit_en, byte_done;
  logic [7:0]          byte_nxt;
  logic [7:0]          pix_val;

  assign sck_rise  = sck_s2 & ~sck_s3;
  assign sck_fall  = ~sck_s2 & sck_s3;
  assign ss_rise   = ss_s2 & ~ss_s3;
  assign ss_fall   = ~ss_s2 & ss_s3;
  // Deassertion wins over a completing byte, so the byte is simply not seen.
  assign bit_en    = sck_rise & ~ss_s2 & ~ss_rise;
  assign byte_done = bit_en & (bit_cnt == 3'd7);
  assign byte_nxt  = {shreg[6:0], mosi_s2};

`ifdef PIXEL_THRESH_EN
  assign pix_val = byte_nxt[7] ? 8'hFF : 8'h00;
`else
  assign pix_val = byte_nxt;
`endif

  // Two-flop synchronizers; the third SCK/SS flop gives edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_s3 <= 1'b0;
      ss_s1  <= 1'b1; ss_s2  <= 1'b1; ss_s3  <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
    end else begin
      sck_s1 <= SCK;  sck_s2 <= sck_s1; sck_s3 <= sck_s2;
      ss_s1  <= SS;   ss_s2  <= ss_s1;  ss_s3  <= ss_s2;
      mosi_s1 <= MOSI; mosi_s2 <= mosi_s1;
    end
  end

  // Registered SCK falling-edge pulse, only while the slave is selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_edge <= 1'b0;
    else     sig_edge <= sck_fall & ~ss_s2;
  end

  // Shift in MOSI on each rising edge; publish the byte on the 8th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      SPI_in    <= 8'h00;
      shift_SPI <= 1'b0;
    end else begin
      shift_SPI <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= 3'd0;
        shreg   <= 8'h00;
      end else if (bit_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= byte_nxt;
        if (bit_cnt == 3'd7) begin
          SPI_in    <= byte_nxt;
          shift_SPI <= 1'b1;
        end
      end
    end
  end

  // Command / pixel FSM; all strobes registered so they line up with shift_SPI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      cost_req     <= 1'b0;
      pixel_wr     <= 1'b0;
      pixel_data   <= 8'h00;
      pixel_addr   <= '0;
      image_loaded <= 1'b0;
    end else begin
      cost_req     <= 1'b0;
      pixel_wr     <= 1'b0;
      image_loaded <= 1'b0;
      if (ss_rise) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (ss_fall) state <= CMD;
          CMD: begin
            if (byte_done) begin
              if (byte_nxt == CMD_COST) begin
                cost_req <= 1'b1;
              end else if (byte_nxt == CMD_IMAGE) begin
                addr_q <= '0;
                state  <= PIXELS;
              end
            end
          end
          PIXELS: begin
            if (byte_done) begin
              pixel_wr   <= 1'b1;
              pixel_data <= pix_val;
              pixel_addr <= addr_q;
              if (addr_q == LAST_ADDR) state <= DONE;
              else                     addr_q <= addr_q + 1'b1;
            end
          end
          DONE: begin
            image_loaded <= 1'b1;
            state        <= CMD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_input_controller.sv
// Self-checking bench for spi_input_controller: drives SPI frames and compares
// observed strobes against a byte-level protocol model.
module tb_spi_input_controller;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;
  localparam int HALF       = 4;   // clk cycles per SCK phase

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              SCK = 1'b0;
  logic              SS  = 1'b1;
  logic              MOSI = 1'b0;
  logic [7:0]        SPI_in;
  logic              shift_SPI, sig_edge, cost_req, pixel_wr, image_loaded;
  logic [7:0]        pixel_data;
  logic [ADDR_W-1:0] pixel_addr;

  spi_input_controller #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .SPI_in(SPI_in), .shift_SPI(shift_SPI), .sig_edge(sig_edge),
    .cost_req(cost_req), .pixel_data(pixel_data), .pixel_addr(pixel_addr),
    .pixel_wr(pixel_wr), .image_loaded(image_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observed events
  logic [7:0]  a_spi[$];
  logic [17:0] a_wr[$];
  int a_cost = 0, a_loaded = 0, a_edge = 0, a_misalign = 0;

  // expected events from the model
  logic [7:0]  e_spi[$];
  logic [17:0] e_wr[$];
  int e_cost = 0, e_loaded = 0, e_edge = 0;

  // model state: receiving pixels or commands, and next pixel index
  bit m_pix = 0;
  int m_addr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sig_edge) a_edge++;
      if (shift_SPI) a_spi.push_back(SPI_in);
      if (cost_req) begin a_cost++; if (!shift_SPI) a_misalign++; end
      if (pixel_wr) begin
        a_wr.push_back({pixel_addr, pixel_data});
        if (!shift_SPI) a_misalign++;
      end
      if (image_loaded) a_loaded++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [7:0] b);
`ifdef PIXEL_THRESH_EN
    return (b >= 8'h80) ? 8'hFF : 8'h00;
`else
    return b;
`endif
  endfunction

  // protocol model for one fully received byte
  task automatic model_byte(input logic [7:0] b);
    e_spi.push_back(b);
    if (!m_pix) begin
      if (b == 8'h01) e_cost++;
      else if (b == 8'h02) begin m_pix = 1; m_addr = 0; end
    end else begin
      e_wr.push_back({ADDR_W'(m_addr), pix_of(b)});
      if (m_addr == NUM_PIXELS - 1) begin e_loaded++; m_pix = 0; end
      else m_addr++;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk); MOSI = b[i];
      repeat (HALF) @(negedge clk);
      SCK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCK = 1'b0;
    end
    e_edge += nbits;
    if (nbits == 8) model_byte(b);
  endtask

  task automatic frame_start();
    SS = 1'b0; m_pix = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    SS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_all();
    a_spi.delete(); a_wr.delete(); e_spi.delete(); e_wr.delete();
    a_cost = 0; a_loaded = 0; a_edge = 0; a_misalign = 0;
    e_cost = 0; e_loaded = 0; e_edge = 0;
  endtask

  task automatic compare_all(input string tag);
    int bad;
    chk({tag, ".nbytes"}, a_spi.size(), e_spi.size());
    bad = 0;
    foreach (e_spi[i]) if (i >= a_spi.size() || a_spi[i] !== e_spi[i]) bad++;
    chk({tag, ".bytes_bad"}, bad, 0);
    chk({tag, ".nwr"}, a_wr.size(), e_wr.size());
    bad = 0;
    foreach (e_wr[i]) if (i >= a_wr.size() || a_wr[i] !== e_wr[i]) bad++;
    chk({tag, ".wr_bad"}, bad, 0);
    chk({tag, ".cost"}, a_cost, e_cost);
    chk({tag, ".loaded"}, a_loaded, e_loaded);
    chk({tag, ".edges"}, a_edge, e_edge);
    chk({tag, ".misalign"}, a_misalign, 0);
    clear_all();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".outs"},
        {SPI_in, pixel_data, 6'(pixel_addr), shift_SPI, sig_edge, cost_req, pixel_wr, image_loaded, 5'd0},
        32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] last;
    // reset state
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_outs_zero("post_reset");

    // reset mid-frame during SCK activity
    frame_start();
    send_bits(8'hFF, 3);
    @(negedge clk); MOSI = 1'b1;
    repeat (HALF) @(negedge clk);
    SCK = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs_zero("mid_reset");
    SCK = 1'b0; SS = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    clear_all();
    repeat (20) @(negedge clk);
    chk({"reset_quiet"}, a_spi.size() + a_edge + a_cost + a_wr.size() + a_loaded, 0);
    clear_all();

    // single byte A5 plus random bytes
    frame_start();
    send_bits(8'hA5, 8);
    frame_end();
    compare_all("a5");
    chk("a5.spi_in", SPI_in, 8'hA5);
    frame_start();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(3, 255));
      send_bits(b, 8);
    end
    frame_end();
    compare_all("rand_bytes");

    // cost command twice
    frame_start();
    send_bits(8'h01, 8);
    send_bits(8'h01, 8);
    frame_end();
    chk("cost.count", a_cost, 2);
    compare_all("cost");

    // full image then cost request in the same frame
    frame_start();
    send_bits(8'h02, 8);
    for (int i = 0; i < NUM_PIXELS; i++) send_bits(8'(i % 256), 8);
    send_bits(8'h01, 8);
    frame_end();
    chk("image.wr", a_wr.size(), NUM_PIXELS);
    chk("image.last", a_wr.size() > 0 ? {14'd0, a_wr[a_wr.size()-1]} : 32'hFFFF_FFFF,
        {14'd0, 10'(NUM_PIXELS - 1), pix_of(8'(NUM_PIXELS - 1))});
    chk("image.loaded", a_loaded, 1);
    compare_all("image");

    // abort after 10 random pixels and 5 bits of the 11th
    frame_start();
    send_bits(8'h02, 8);
    last = 8'h00;
    for (int i = 0; i < 10; i++) begin
      last = 8'($urandom);
      send_bits(last, 8);
    end
    send_bits(8'($urandom), 5);
    frame_end();
    chk("abort.spi_in", SPI_in, last);
    chk("abort.wr", a_wr.size(), 10);
    compare_all("abort");

    // restart at address 0
    frame_start();
    send_bits(8'h02, 8);
    for (int i = 0; i < 3; i++) send_bits(8'($urandom), 8);
    frame_end();
    chk("restart.addr0", a_wr.size() > 0 ? {22'd0, a_wr[0][17:8]} : 32'hFFFF_FFFF, 32'd0);
    compare_all("restart");

    // unknown commands, then threshold boundary pixels
    frame_start();
    send_bits(8'h7E, 8);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(3, 255));
      send_bits(b, 8);
    end
    chk("unknown.quiet", a_cost + a_wr.size(), 0);
    send_bits(8'h02, 8);
    send_bits(8'h80, 8);
    send_bits(8'h7F, 8);
    frame_end();
    compare_all("thresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
